// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StShow,
    StGap
  } state_e;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Index n holds the glyph for nibble n (0-9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] GLYPH_ROM = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data in, scanned segment/select drive out.
interface seg7_scan_driver_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  hex_mode;
  logic                  lz_blank;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   sel;
  logic                  frame_done;

  modport master (
    output data, dp_in, hex_mode, lz_blank,
    input  seg, dp, sel, frame_done
  );

  modport slave (
    input  data, dp_in, hex_mode, lz_blank,
    output seg, dp, sel, frame_done
  );
endinterface

// File: rtl/seg7_glyph_enc.sv
// Nibble to active-high seven-segment pattern; polarity is applied by the caller.
module seg7_glyph_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] pattern
);

  // Blank wins; BCD mode shows a dash for out-of-range nibbles.
  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      if (!hex_mode && (nibble > 4'd9)) begin
        pattern = SEG_DASH;
      end else begin
        pattern = GLYPH_ROM[nibble];
      end
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with per-frame snapshot and blanking gap.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned DWELL_CYC      = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input logic               CLK_50M,
  input logic               RST,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(max_u(DWELL_CYC, BLANK_CYC) + 1);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  // Off levels double as XOR masks to convert active-high values to pin polarity.
  localparam logic [N_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] SEL_ONE = N_DIGITS'(1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] snap_data_q, snap_data_d;
  logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                  snap_hex_q, snap_hex_d;
  logic                  snap_lz_q, snap_lz_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   sel_q, sel_d;
  logic                  frame_done_q, frame_done_d;

  logic                  advance;
  logic [3:0]            nibble;
  logic                  lead_blank;
  logic [6:0]            pattern;

  // Scan sequencing: LOAD snapshot, then SHOW/GAP per digit, wrapping to LOAD.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    snap_data_d  = snap_data_q;
    snap_dp_d    = snap_dp_q;
    snap_hex_d   = snap_hex_q;
    snap_lz_d    = snap_lz_q;
    frame_done_d = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      StLoad: begin
        snap_data_d = bus.data;
        snap_dp_d   = bus.dp_in;
        snap_hex_d  = bus.hex_mode;
        snap_lz_d   = bus.lz_blank;
        idx_d       = '0;
        cnt_d       = '0;
        state_d     = StShow;
      end
      StShow: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (BLANK_CYC > 0) begin
            state_d = StGap;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase

    if (advance) begin
      if (idx_q != IDX_LAST) begin
        idx_d   = idx_q + 1'b1;
        state_d = StShow;
      end else begin
        state_d      = StLoad;
        frame_done_d = 1'b1;
      end
    end
  end

  // Leading-zero test on the digit about to be shown; digit 0 always displays.
  always_comb begin
    nibble     = snap_data_d[4*idx_d +: 4];
    lead_blank = snap_lz_d;
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((i >= int'(idx_d)) && (snap_data_d[4*i +: 4] != 4'h0)) begin
        lead_blank = 1'b0;
      end
    end
    if (idx_d == '0) begin
      lead_blank = 1'b0;
    end
  end

  seg7_glyph_enc u_glyph_enc (
    .nibble   (nibble),
    .hex_mode (snap_hex_d),
    .blank    (lead_blank),
    .pattern  (pattern)
  );

  // Output drive follows the next state so registered pins line up with state_q.
  always_comb begin
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (state_d == StShow) begin
      sel_d = SEL_OFF ^ (SEL_ONE << idx_d);
      seg_d = SEG_OFF ^ pattern;
      dp_d  = DP_OFF ^ snap_dp_d[idx_d];
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) begin
      state_q      <= StLoad;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      snap_hex_q   <= 1'b0;
      snap_lz_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      sel_q        <= SEL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      snap_hex_q   <= snap_hex_d;
      snap_lz_q    <= snap_lz_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.sel        = sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: two scanner configurations checked against a frame-position model.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int DA = 4;
  localparam int BA = 1;
  localparam int DB = 3;
  localparam int BB = 0;
  localparam int FA = 1 + N * (DA + BA);
  localparam int FB = 1 + N * (DB + BB);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        hex_mode = 1'b0;
  logic        lz_blank = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fd_a = -1;
  int last_fd_b = -1;
  int pos_a = 0;
  int pos_b = 0;

  logic [12:0] q_a[$];
  logic [12:0] q_b[$];

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(N)) bus_a ();
  seg7_scan_driver_if #(.N_DIGITS(N)) bus_b ();

  assign bus_a.data     = data;
  assign bus_a.dp_in    = dp_in;
  assign bus_a.hex_mode = hex_mode;
  assign bus_a.lz_blank = lz_blank;
  assign bus_b.data     = data;
  assign bus_b.dp_in    = dp_in;
  assign bus_b.hex_mode = hex_mode;
  assign bus_b.lz_blank = lz_blank;

  seg7_scan_driver #(
    .N_DIGITS       (N),
    .DWELL_CYC      (DA),
    .BLANK_CYC      (BA),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) u_dut_a (
    .CLK_50M (clk),
    .RST     (rst_n),
    .bus     (bus_a)
  );

  seg7_scan_driver #(
    .N_DIGITS       (N),
    .DWELL_CYC      (DB),
    .BLANK_CYC      (BB),
    .SEG_ACTIVE_LOW (1'b0),
    .SEL_ACTIVE_LOW (1'b0)
  ) u_dut_b (
    .CLK_50M (clk),
    .RST     (rst_n),
    .bus     (bus_b)
  );

  // Expected {frame_done, sel, seg, dp} for a given cycle position within a frame.
  function automatic logic [12:0] expect_out(int pos, int dw, int bl, logic [15:0] d,
                                             logic [3:0] dv, logic hx, logic lz,
                                             bit seg_al, bit sel_al, bit fd);
    logic [3:0] s;
    logic [6:0] g;
    logic       p;
    logic [3:0] nib;
    int q, k, r;
    s = '0;
    g = '0;
    p = 1'b0;
    if (pos != 0) begin
      q = pos - 1;
      k = q / (dw + bl);
      r = q % (dw + bl);
      if (r < dw) begin
        s   = 4'(1 << k);
        nib = d[4*k +: 4];
        p   = dv[k];
        if (lz && k > 0 && (d >> (4 * k)) == 16'h0) g = 7'h00;
        else if (!hx && nib > 4'd9) g = 7'h40;
        else g = glyph[nib];
      end
    end
    if (sel_al) s = ~s;
    if (seg_al) begin
      g = ~g;
      p = ~p;
    end
    return {fd, s, g, p};
  endfunction

  // Reference model A: tracks frame position, snapshots inputs at the LOAD cycle.
  initial begin
    logic [15:0] sd;
    logic [3:0]  sp;
    logic        sh, sl;
    sd = '0; sp = '0; sh = 1'b0; sl = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pos_a = 0;
        q_a.delete();
      end else begin
        if (pos_a == 0) begin
          sd = data; sp = dp_in; sh = hex_mode; sl = lz_blank;
        end
        pos_a = (pos_a + 1) % FA;
        q_a.push_back(expect_out(pos_a, DA, BA, sd, sp, sh, sl, 1'b1, 1'b1, pos_a == 0));
      end
    end
  end

  // Reference model B: no gap, active-high outputs.
  initial begin
    logic [15:0] sd;
    logic [3:0]  sp;
    logic        sh, sl;
    sd = '0; sp = '0; sh = 1'b0; sl = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pos_b = 0;
        q_b.delete();
      end else begin
        if (pos_b == 0) begin
          sd = data; sp = dp_in; sh = hex_mode; sl = lz_blank;
        end
        pos_b = (pos_b + 1) % FB;
        q_b.push_back(expect_out(pos_b, DB, BB, sd, sp, sh, sl, 1'b0, 1'b0, pos_b == 0));
      end
    end
  end

  // Monitor: pop one expectation per cycle per DUT; also check frame_done spacing.
  initial begin
    logic [12:0] exp_v, got;
    forever begin
      @(negedge clk);
      cyc++;
      if (q_a.size() > 0) begin
        exp_v = q_a.pop_front();
        got   = {bus_a.frame_done, bus_a.sel, bus_a.seg, bus_a.dp};
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL scan_a cyc=%0d got=%b exp=%b", cyc, got, exp_v);
        end
        if (bus_a.frame_done === 1'b1) begin
          if (last_fd_a >= 0) begin
            checks++;
            if (cyc - last_fd_a != FA) begin
              errors++;
              $display("FAIL frame_len_a got=%0d exp=%0d", cyc - last_fd_a, FA);
            end
          end
          last_fd_a = cyc;
        end
      end
      if (q_b.size() > 0) begin
        exp_v = q_b.pop_front();
        got   = {bus_b.frame_done, bus_b.sel, bus_b.seg, bus_b.dp};
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL scan_b cyc=%0d got=%b exp=%b", cyc, got, exp_v);
        end
        if (bus_b.frame_done === 1'b1) begin
          if (last_fd_b >= 0) begin
            checks++;
            if (cyc - last_fd_b != FB) begin
              errors++;
              $display("FAIL frame_len_b got=%0d exp=%0d", cyc - last_fd_b, FB);
            end
          end
          last_fd_b = cyc;
        end
      end
    end
  end

  task automatic check_off(string name);
    logic [12:0] ea, eb, ga, gb;
    ea = expect_out(0, DA, BA, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    eb = expect_out(0, DB, BB, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ga = {bus_a.frame_done, bus_a.sel, bus_a.seg, bus_a.dp};
    gb = {bus_b.frame_done, bus_b.sel, bus_b.seg, bus_b.dp};
    checks += 2;
    if (ga !== ea) begin
      errors++;
      $display("FAIL %s_a got=%b exp=%b", name, ga, ea);
    end
    if (gb !== eb) begin
      errors++;
      $display("FAIL %s_b got=%b exp=%b", name, gb, eb);
    end
  endtask

  // Called at a negedge; holds the inputs for the given number of cycles.
  task automatic apply(logic [15:0] d, logic [3:0] dv, logic hx, logic lz, int cycles);
    data = d; dp_in = dv; hex_mode = hx; lz_blank = lz;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    logic [15:0] mask;
    repeat (3) @(negedge clk);
    check_off("reset_state");
    #2 rst_n = 1'b1;
    @(negedge clk);

    apply(16'h1234, 4'b0000, 1'b0, 1'b0, 2 * FA);
    apply(16'h00AF, 4'b0000, 1'b0, 1'b1, 2 * FA);
    apply(16'h00AF, 4'b0001, 1'b1, 1'b1, 2 * FA);
    apply(16'h0000, 4'b1000, 1'b0, 1'b1, 2 * FA);
    apply(16'h0105, 4'b0000, 1'b0, 1'b1, 2 * FA);
    apply(16'h5A3C, 4'b0100, 1'b1, 1'b0, 2 * FA);

    // Change data during digit 1 of DUT A; the running frame must keep the old value.
    data = 16'h1111; dp_in = 4'b0000; hex_mode = 1'b0; lz_blank = 1'b0;
    for (int i = 0; i < 3 * FA && pos_a != 7; i++) @(negedge clk);
    data = 16'h2222;
    repeat (2 * FA) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      apply(16'($urandom) & mask, 4'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(3, 50)));
    end

    // Reset asserted while DUT A shows digit 2: outputs must go off immediately.
    data = 16'h9876; dp_in = 4'b1111; hex_mode = 1'b0; lz_blank = 1'b0;
    for (int i = 0; i < 3 * FA && pos_a != 12; i++) @(negedge clk);
    if (pos_a != 12) begin
      checks++;
      errors++;
      $display("FAIL reach_digit2 got=%0d exp=12", pos_a);
    end
    #2 rst_n = 1'b0;
    #1 check_off("async_reset");
    last_fd_a = -1;
    last_fd_b = -1;
    @(negedge clk);
    check_off("reset_held");
    #2 rst_n = 1'b1;
    @(negedge clk);
    apply(16'h4321, 4'b0010, 1'b0, 1'b0, 3 * FA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
